// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receive states and default constants
package uart_pkg;

    localparam int   UART_OVERSAMPLE = 16;
    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE       = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for an asynchronous input with configurable reset level
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    // shift the async input through two flops before anyone looks at it
    always_ff @(posedge clk or posedge rst)
        if (rst) ff_q <= {2{RST_VAL}};
        else     ff_q <= {ff_q[0], d_i};

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: start-aligned UART frame receiver; optional even parity via UART_RX_PARITY_EN
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    uart_rx_state_t       state_q, state_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 prev_q;
    logic                 rx_s;
    logic                 par_err;

    uart_rx_sync #(.RST_VAL(UART_IDLE)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_in),
        .q_o (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign par_err = ^{sh_q, par_q};
`else
    assign par_err = 1'b0;
`endif

    // frame sequencing: counters clear on every state entry, a tick in the entry cycle counts as the first
    always_comb begin
        state_d = state_q;
        tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE:
                if (!rx_s && prev_q) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                end
            ST_START:
                if (tick && tcnt_q == T_HALF) begin
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                end
            ST_DATA:
                if (tick && tcnt_q == T_FULL) begin
                    tcnt_d = '0;
                    sh_d   = {rx_s, sh_q[DATA_BITS-1:1]};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        bcnt_d  = '0;
                    end
                end
`ifdef UART_RX_PARITY_EN
            ST_PARITY:
                if (tick && tcnt_q == T_FULL) begin
                    par_d   = rx_s;
                    state_d = ST_STOP;
                    tcnt_d  = '0;
                end
`endif
            ST_STOP:
                if (tick && tcnt_q == T_FULL) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                    if (rx_s && !par_err) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and datapath registers; prev_q makes IDLE wait for a high-to-low edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            prev_q  <= UART_IDLE;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            prev_q  <= rx_s;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = state_q != ST_IDLE;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with serial-line stimulus and frame-level model
module tb_uart_rx_ctrl;

    localparam int OS     = 16;
    localparam int DB     = 8;
    localparam int TDIV   = 4;
    localparam int BITCLK = OS * TDIV;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    exp_t       q[$];
    logic [7:0] last_good = 8'h00;
    int         checks = 0;
    int         passed = 0;
    int         tdiv_cnt = 0;
    logic       prev_tick = 1'b0;

    uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tdiv_cnt <= (tdiv_cnt == TDIV - 1) ? 0 : tdiv_cnt + 1;
        tick     <= (tdiv_cnt == TDIV - 1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (data_valid || frame_err)) begin
            chk("valid_err_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
            chk("pulse_after_tick", {31'd0, prev_tick}, 32'd1);
            chk("pulse_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.err});
                chk("data_out", {24'd0, data_out}, {24'd0, e.data});
            end
        end
        prev_tick = tick;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        wait_clk(BITCLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip, input int abort_bit);
        logic good;
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) begin
            if (i == abort_bit) begin
                wait_clk(BITCLK / 2);
                rst = 1'b1;
                wait_clk(3);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                rst = 1'b0;
                rx_in = 1'b1;
                last_good = 8'h00;
                wait_clk(2 * BITCLK);
                chk("abort_data_cleared", {24'd0, data_out}, {24'd0, last_good});
                return;
            end
            send_bit(d[i]);
        end
`ifdef UART_RX_PARITY_EN
        send_bit(^d ^ par_flip);
        good = stop_b && !par_flip;
`else
        good = stop_b;
`endif
        if (good) last_good = d;
        q.push_back('{err: !good, data: last_good});
        send_bit(stop_b);
        rx_in = 1'b1;
        if (!stop_b) send_bit(1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int bcnt;
        rx_in = 1'b1;
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(20 * TDIV);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        send_frame(8'hA5, 1'b1, 1'b0, -1);
        send_bit(1'b1);

        rx_in = 1'b0;
        wait_clk(4 * TDIV);
        rx_in = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 2 * BITCLK; i++) begin
            wait_clk(1);
            if (busy) bcnt++;
        end
        chk("glitch_busy_seen", {31'd0, bcnt > 0}, 32'd1);
        chk("glitch_busy_bounded", {31'd0, bcnt <= 8 * TDIV}, 32'd1);
        chk("glitch_data_kept", {24'd0, data_out}, {24'd0, last_good});

        send_frame(8'h3C, 1'b0, 1'b0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_bit(1'b1);

        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_bit(1'b1);

        send_frame(8'h55, 1'b1, 1'b0, 4);
`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b1, -1);
        send_bit(1'b1);
`endif
        send_frame(8'h81, 1'b1, 1'b0, -1);
        send_bit(1'b1);

        q.push_back('{err: 1'b1, data: last_good});
        rx_in = 1'b0;
        wait_clk(20 * BITCLK);
        rx_in = 1'b1;
        wait_clk(2 * BITCLK);

        for (int n = 0; n < 25; n++) begin
            send_frame(8'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0, -1);
            if ($urandom_range(0, 1) == 1) send_bit(1'b1);
        end
        rx_in = 1'b1;

        for (int i = 0; i < 4 * BITCLK && q.size() != 0; i++) wait_clk(1);
        wait_clk(BITCLK);
        chk("scoreboard_drained", q.size(), 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
